// File: rtl/sweep_max_counter.sv
// Servo sweep step counter and peak-light tracker feeding the tracker FSM's status inputs.
// Latency: flags are decoded combinationally from registers; counters advance one step per STEP_DIV cycles.
// Backpressure: none; the enables are level inputs and ADC samples without ADC_VALID are ignored.
module sweep_max_counter #(
    parameter int SWEEP_STEPS = 180,
    parameter int STEP_DIV    = 100000,
    parameter int ADC_W       = 12,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CNT_RST,
    input  logic             HS,
    input  logic             VS,
    input  logic             MC,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    output logic             CNT_L,
    output logic             CNT_D,
    output logic             CNT_RU,
    output logic [ADC_W-1:0] MAX_VAL,
    output logic [CNT_W-1:0] MAX_IDX,
    output logic [CNT_W-1:0] STEP_CNT
);

    localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] STEPS    = CNT_W'(SWEEP_STEPS);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [ADC_W-1:0] max_val;
    logic [CNT_W-1:0] max_idx;
    logic             axis;
    logic             hs_q;
    logic             vs_q;
    logic             mc_q;

    logic             clr;
    logic             vs_en;
    logic             hs_rise;
    logic             vs_rise;
    logic             mc_rise;
    logic             sweep;
    logic             run;
    logic             tick;
    logic [CNT_W-1:0] cur_cnt;
    logic             track;

    // Qualify enables and decode edges; HS overrides VS, so VS only counts as enabled while HS is low.
    always_comb begin
        clr     = RST | CNT_RST;
        vs_en   = VS & ~HS;
        hs_rise = HS & ~hs_q;
        vs_rise = vs_en & ~vs_q;
        mc_rise = MC & ~mc_q;
        sweep   = HS | VS;
        run     = sweep | (MC & (ret_cnt != '0));
        tick    = run & (div_cnt == DIV_LAST) & ~(hs_rise | vs_rise);
        cur_cnt = HS ? h_cnt : v_cnt;
        track   = sweep & ADC_VALID & (cur_cnt < STEPS) & ~(hs_rise | vs_rise);
    end

    // Output decode straight from registers so the flags are stable when the FSM enters a state.
    always_comb begin
        CNT_L    = (h_cnt != STEPS);
        CNT_D    = (v_cnt != STEPS);
        CNT_RU   = (ret_cnt != '0);
        MAX_VAL  = max_val;
        MAX_IDX  = max_idx;
        STEP_CNT = axis ? v_cnt : h_cnt;
    end

    // Step prescaler: restarts on a sweep start so the first step takes a full STEP_DIV cycles.
    always_ff @(posedge CLK) begin
        if (clr || hs_rise || vs_rise || !run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Edge-detect history; vs_q tracks the qualified VS so VS left high after HS drops starts a fresh sweep.
    always_ff @(posedge CLK) begin
        if (clr) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            mc_q <= 1'b0;
        end else begin
            hs_q <= HS;
            vs_q <= vs_en;
            mc_q <= MC;
        end
    end

    // Sweep step counters, axis select and peak capture; strict compare keeps the earliest index on ties.
    always_ff @(posedge CLK) begin
        if (clr) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            max_val <= '0;
            max_idx <= '0;
            axis    <= 1'b0;
        end else if (hs_rise) begin
            h_cnt   <= '0;
            max_val <= '0;
            max_idx <= '0;
            axis    <= 1'b0;
        end else if (vs_rise) begin
            v_cnt   <= '0;
            max_val <= '0;
            max_idx <= '0;
            axis    <= 1'b1;
        end else begin
            if (track && (ADC_DATA > max_val)) begin
                max_val <= ADC_DATA;
                max_idx <= cur_cnt;
            end
            if (tick && HS && (h_cnt < STEPS)) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end else if (tick && vs_en && (v_cnt < STEPS)) begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end
    end

    // Return-to-peak countdown: loaded on an MC rise outside a sweep, cleared whenever MC is low.
    always_ff @(posedge CLK) begin
        if (clr || !MC) begin
            ret_cnt <= '0;
        end else if (sweep) begin
            ret_cnt <= ret_cnt;
        end else if (mc_rise) begin
            ret_cnt <= STEPS - max_idx;
        end else if (tick && (ret_cnt != '0)) begin
            ret_cnt <= ret_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sweep_max_counter.sv
// Directed bench for sweep_max_counter with an elapsed-time reference model checked every cycle.
module tb_sweep_max_counter;

    localparam int SW = 8;
    localparam int SD = 4;
    localparam int AW = 12;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CNT_RST = 1'b0;
    logic          HS = 1'b0;
    logic          VS = 1'b0;
    logic          MC = 1'b0;
    logic [AW-1:0] ADC_DATA = '0;
    logic          ADC_VALID = 1'b0;
    logic          CNT_L;
    logic          CNT_D;
    logic          CNT_RU;
    logic [AW-1:0] MAX_VAL;
    logic [CW-1:0] MAX_IDX;
    logic [CW-1:0] STEP_CNT;

    sweep_max_counter #(
        .SWEEP_STEPS(SW),
        .STEP_DIV   (SD),
        .ADC_W      (AW),
        .CNT_W      (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CNT_RST  (CNT_RST),
        .HS       (HS),
        .VS       (VS),
        .MC       (MC),
        .ADC_DATA (ADC_DATA),
        .ADC_VALID(ADC_VALID),
        .CNT_L    (CNT_L),
        .CNT_D    (CNT_D),
        .CNT_RU   (CNT_RU),
        .MAX_VAL  (MAX_VAL),
        .MAX_IDX  (MAX_IDX),
        .STEP_CNT (STEP_CNT)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b1;
    int pat       = 0;

    // Reference model: step counts derived from edges elapsed since the sweep/return started.
    int m_h = 0, m_v = 0, m_hel = 0, m_vel = 0;
    int m_ret = 0, m_ret0 = 0, m_rel = 0;
    int m_max = 0, m_idx = 0;
    bit m_axis = 0, m_hsq = 0, m_vsq = 0, m_mcq = 0;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int steps_after(input int edges);
        int s;
        s = edges / SD;
        return (s > SW) ? SW : s;
    endfunction

    always @(posedge CLK) begin : model
        bit hr, ve, vr;
        int cur, r;
        if (RST || CNT_RST) begin
            m_h = 0; m_v = 0; m_hel = 0; m_vel = 0;
            m_ret = 0; m_ret0 = 0; m_rel = 0;
            m_max = 0; m_idx = 0;
            m_axis = 0; m_hsq = 0; m_vsq = 0; m_mcq = 0;
        end else begin
            hr = HS && !m_hsq;
            ve = VS && !HS;
            vr = ve && !m_vsq;
            if (!MC) m_ret = 0;
            else if (HS || VS) m_ret = m_ret;
            else if (!m_mcq) begin
                m_ret0 = SW - m_idx; m_ret = m_ret0; m_rel = 0;
            end else if (m_ret != 0) begin
                m_rel++;
                r = m_ret0 - m_rel / SD;
                m_ret = (r < 0) ? 0 : r;
            end
            if (hr) begin
                m_h = 0; m_hel = 0; m_max = 0; m_idx = 0; m_axis = 0;
            end else if (vr) begin
                m_v = 0; m_vel = 0; m_max = 0; m_idx = 0; m_axis = 1;
            end else if (HS || ve) begin
                cur = HS ? m_h : m_v;
                if (ADC_VALID && cur < SW && int'(ADC_DATA) > m_max) begin
                    m_max = int'(ADC_DATA); m_idx = cur;
                end
                if (HS) begin m_hel++; m_h = steps_after(m_hel); end
                else    begin m_vel++; m_v = steps_after(m_vel); end
            end
            m_hsq = HS; m_vsq = ve; m_mcq = MC;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            check("cnt_l",    CNT_L,    int'(m_h != SW));
            check("cnt_d",    CNT_D,    int'(m_v != SW));
            check("cnt_ru",   CNT_RU,   int'(m_ret != 0));
            check("max_val",  MAX_VAL,  m_max);
            check("max_idx",  MAX_IDX,  m_idx);
            check("step_cnt", STEP_CNT, m_axis ? m_v : m_h);
        end
    end

    // ADC stimulus patterns keyed off the model's current step.
    always @(negedge CLK) begin
        case (pat)
            1: begin ADC_VALID = 1; ADC_DATA = AW'((m_h <= 5) ? 100 + 50 * m_h : 20); end
            2: begin ADC_VALID = 1; ADC_DATA = AW'(200 + 10 * m_h); end
            3: begin ADC_VALID = 1; ADC_DATA = AW'((m_v == 2 || m_v == 6) ? 500 : 100); end
            default: begin ADC_VALID = 0; ADC_DATA = '0; end
        endcase
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(posedge CLK);
        #2;
        check("rst_cnt_l", CNT_L, 1);
        check("rst_cnt_d", CNT_D, 1);
        check("rst_cnt_ru", CNT_RU, 0);
        check("rst_step", STEP_CNT, 0);
        @(negedge CLK) RST = 0;

        // Horizontal sweep with peak at step 5
        @(negedge CLK) begin HS = 1; pat = 1; end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #2; n++;
            if (!CNT_L) break;
        end
        check("h_fall_cycles", n, 33);
        check("h_max_val", MAX_VAL, 350);
        check("h_max_idx", MAX_IDX, 5);

        // Return to step 5: 3 steps of 4 cycles
        @(negedge CLK) begin HS = 0; MC = 1; pat = 0; end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #2;
            if (CNT_RU) n++; else break;
        end
        check("ret3_high_cycles", n, 12);
        @(negedge CLK) MC = 0;

        // Increasing ramp: peak on the final step
        @(negedge CLK) begin HS = 1; pat = 2; end
        repeat (36) @(posedge CLK);
        #2;
        check("ramp_cnt_l", CNT_L, 0);
        check("ramp_max_idx", MAX_IDX, 7);
        check("ramp_max_val", MAX_VAL, 270);
        @(negedge CLK) begin HS = 0; MC = 1; pat = 0; end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #2;
            if (CNT_RU) n++; else break;
        end
        check("ret1_high_cycles", n, 4);
        @(negedge CLK) MC = 0;

        // Vertical sweep with tied peaks at steps 2 and 6
        @(negedge CLK) begin VS = 1; pat = 3; end
        repeat (36) @(posedge CLK);
        #2;
        check("tie_max_idx", MAX_IDX, 2);
        check("tie_max_val", MAX_VAL, 500);
        check("v_step_cnt", STEP_CNT, 8);
        check("v_cnt_d", CNT_D, 0);
        check("v_cnt_l_kept", CNT_L, 0);
        @(negedge CLK) begin VS = 0; pat = 0; RST = 1; end
        @(negedge CLK) RST = 0;

        // HS and VS together: only horizontal advances
        @(negedge CLK) begin HS = 1; VS = 1; end
        repeat (12) @(posedge CLK);
        #2;
        check("both_cnt_d", CNT_D, 1);
        check("both_step_cnt", STEP_CNT, 2);

        // Reset mid-sweep
        @(negedge CLK) begin HS = 0; VS = 0; RST = 1; end
        @(posedge CLK); #2;
        check("midrst_cnt_l", CNT_L, 1);
        check("midrst_cnt_d", CNT_D, 1);
        check("midrst_max", MAX_VAL, 0);
        check("midrst_step", STEP_CNT, 0);
        @(negedge CLK) RST = 0;

        // Reset mid-return
        @(negedge CLK) begin HS = 1; pat = 1; end
        repeat (36) @(posedge CLK);
        @(negedge CLK) begin HS = 0; MC = 1; pat = 0; end
        repeat (3) @(posedge CLK);
        #2;
        check("pre_rst_cnt_ru", CNT_RU, 1);
        @(negedge CLK) begin MC = 0; RST = 1; end
        @(posedge CLK); #2;
        check("retrst_cnt_ru", CNT_RU, 0);
        check("retrst_cnt_l", CNT_L, 1);
        @(negedge CLK) RST = 0;

        // CNT_RST held during an active sweep keeps everything cleared
        @(negedge CLK) begin HS = 1; pat = 1; end
        repeat (10) @(posedge CLK);
        @(negedge CLK) CNT_RST = 1;
        repeat (10) @(posedge CLK);
        #2;
        check("cntrst_step", STEP_CNT, 0);
        check("cntrst_max", MAX_VAL, 0);
        check("cntrst_cnt_l", CNT_L, 1);
        @(negedge CLK) begin CNT_RST = 0; HS = 0; pat = 0; end
        repeat (4) @(posedge CLK);
        #2;
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sweep_max_counter.md
Name: sweep_max_counter

Overview:
- Counter/peak-tracker stage that drives the tracker FSM's sweep-status inputs.
- Consumes the FSM enables HS, VS, MC and CNT_RST, plus light-sensor ADC samples.
- Counts servo steps during horizontal and vertical sweeps and records the step index of peak light.
- Produces CNT_L, CNT_D (sweep not finished) and CNT_RU (return-to-max steps remaining) back to the FSM.

Parameters:
SWEEP_STEPS, 180, servo steps per full sweep on either axis
STEP_DIV, 100000, CLK cycles per servo step tick
ADC_W, 12, sensor sample width
CNT_W, 8, step counter width; must hold SWEEP_STEPS

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
CNT_RST  in  1  synchronous clear of all counters and the tracker, same effect as RST
HS  in  1  horizontal sweep enable
VS  in  1  vertical sweep enable
MC  in  1  max-return enable
ADC_DATA  in  ADC_W  light sample
ADC_VALID  in  1  ADC_DATA valid this cycle
CNT_L  out  1  horizontal sweep in progress
CNT_D  out  1  vertical sweep in progress
CNT_RU  out  1  return steps remaining
MAX_VAL  out  ADC_W  peak sample of current/last sweep
MAX_IDX  out  CNT_W  step index of MAX_VAL
STEP_CNT  out  CNT_W  current sweep step count (debug)

Behaviour:
- Reset: one clock; RST and CNT_RST are synchronous and active-high. Either one clears div_cnt, h_cnt, v_cnt, ret_cnt, MAX_VAL, MAX_IDX, axis, hs_q, vs_q and mc_q to 0.
- Reset output values: CNT_L=1, CNT_D=1, CNT_RU=0, MAX_VAL=0, MAX_IDX=0, STEP_CNT=0. The FSM exits each state combinationally, so the sweep flags must already be 1 when it enters a sweep state.
- Output decoding (combinational from registers):
  - CNT_L = (h_cnt != SWEEP_STEPS)
  - CNT_D = (v_cnt != SWEEP_STEPS)
  - CNT_RU = (ret_cnt != 0)
  - STEP_CNT = axis ? v_cnt : h_cnt
- Prescaler:
  - div_cnt runs only while HS, VS, or (MC and ret_cnt != 0) is high; otherwise it is held at 0.
  - tick = (div_cnt == STEP_DIV-1); div_cnt wraps to 0 on tick.
- Edge detect: hs_q, vs_q and mc_q register HS, VS and MC each cycle.
- HS rising (HS & ~hs_q):
  - h_cnt<=0, MAX_VAL<=0, MAX_IDX<=0, axis<=0.
  - ADC samples in that cycle are ignored.
- VS rising: same clearing on v_cnt, MAX_VAL and MAX_IDX; axis<=1.
- Sweep phase (HS=1, not the rising cycle):
  - On tick with h_cnt < SWEEP_STEPS: h_cnt++. h_cnt saturates at SWEEP_STEPS and never wraps.
  - Same rules apply for VS/v_cnt.
- Peak tracking:
  - Active while (HS or VS) and ADC_VALID and the current counter < SWEEP_STEPS.
  - If ADC_DATA > MAX_VAL (strict): MAX_VAL<=ADC_DATA, MAX_IDX<=current counter (pre-increment value if tick is in the same cycle).
  - Ties keep the earliest index.
- MC rising (MC & ~mc_q): ret_cnt <= SWEEP_STEPS - MAX_IDX.
  - If MAX_IDX == SWEEP_STEPS, ret_cnt=0 and CNT_RU stays 0, so the FSM proceeds immediately.
  - The load happens on the edge ending the FSM's last sweep cycle, so CNT_RU is valid on the first max-state cycle.
- Return phase (MC=1, not the rising cycle): on tick with ret_cnt != 0, ret_cnt--. ret_cnt stops at 0.
- MC falling: ret_cnt<=0.
- Simultaneous enables:
  - HS and VS together (illegal): HS has priority, VS is ignored.
  - MC together with HS/VS: the sweep update wins; ret_cnt is not loaded until MC rises again.
- Reset mid-sweep or mid-return: all counters are cleared next edge; the FSM sees CNT_L=1, CNT_D=1, CNT_RU=0.
- Latency:
  - A sweep flag drops at the edge of the SWEEP_STEPS-th tick, i.e. SWEEP_STEPS*STEP_DIV cycles after the enable rising edge plus 1 cycle.
  - CNT_RU drops after ret*STEP_DIV cycles.

Test Plan:
(Use SWEEP_STEPS=8, STEP_DIV=4, ADC_W=12, CNT_W=8 for all cases.)
1. Reset: RST pulse mid-operation -> next cycle CNT_L=1, CNT_D=1, CNT_RU=0, MAX_VAL=0, STEP_CNT=0.
2. Horizontal sweep:
   - Stimulus: HS=1 held; ADC_VALID every cycle; ADC_DATA = 100 + 50*h_cnt for h_cnt<=5, 20 after.
   - Required: CNT_L falls 33 cycles after the HS rise; MAX_VAL=350, MAX_IDX=5.
3. Return:
   - Stimulus: drop HS, raise MC.
   - Required: ret_cnt=3, CNT_RU=1 for 12 cycles then 0; ret_cnt ends at 0.
4. Peak at end:
   - Stimulus: ramp increasing for all steps 0..7 (MAX_IDX=7), then MC rise.
   - Required: ret=1, CNT_RU high 4 cycles.
5. Tie and priority:
   - Stimulus: equal peaks of 500 at steps 2 and 6.
   - Required: MAX_IDX=2.
   - Stimulus: HS=VS=1.
   - Required: only h_cnt advances, CNT_D stays 1.
6. Full FSM loop (integrate with the tracker FSM):
   - Stimulus: BTN_C pulse.
   - Required: states 1→2→3→4→0 in sequence; vertical MAX_IDX is independent of the horizontal result; CNT_RST in manual holds all counters at 0.
